// File: rtl/serial_and_collector.sv
// Bit-serial word collector: assembles WIDTH accepted bits into a parallel word
// and builds its AND-reduction one bit at a time, then holds the word for a consumer.
module serial_and_collector #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  input  logic             clear,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_all_ones,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             acc;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] shifted;

  // Next shift-register value if the current bit is taken; the first bit of a
  // word always ends up at the end selected by LSB_FIRST once WIDTH bits are in.
  always_comb begin
    shifted = sr;
    if (LSB_FIRST) shifted = {s_data, sr[WIDTH-1:1]};
    else           shifted = {sr[WIDTH-2:0], s_data};
  end

  assign m_valid = (state == HOLD);
  assign s_ready = !m_valid;
  assign busy    = (count != '0);

  // clear only touches the partial word; a held word waits for m_ready alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      count      <= '0;
      acc        <= 1'b1;
      sr         <= '0;
      m_data     <= '0;
      m_all_ones <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (clear) begin
            count <= '0;
            acc   <= 1'b1;
          end else if (s_valid) begin
            sr <= shifted;
            if (count == LAST) begin
              m_data     <= shifted;
              m_all_ones <= acc & s_data;
              count      <= '0;
              acc        <= 1'b1;
              state      <= HOLD;
            end else begin
              count <= count + 1'b1;
              acc   <= acc & s_data;
            end
          end
        end
        HOLD: begin
          if (m_ready) state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_and_collector.sv
// Directed bench for serial_and_collector; an LSB-first and an MSB-first instance
// share one input stream so both bit orders are checked against hand-computed words.
module tb_serial_and_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_data;
  logic       clear;
  logic       m_ready;

  logic       l_s_ready, l_m_valid, l_all_ones, l_busy;
  logic [7:0] l_data;
  logic       h_s_ready, h_m_valid, h_all_ones, h_busy;
  logic [7:0] h_data;

  int total = 0;
  int bad   = 0;

  serial_and_collector #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(l_s_ready),
    .clear(clear), .m_valid(l_m_valid), .m_ready(m_ready), .m_data(l_data),
    .m_all_ones(l_all_ones), .busy(l_busy)
  );

  serial_and_collector #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(h_s_ready),
    .clear(clear), .m_valid(h_m_valid), .m_ready(m_ready), .m_data(h_data),
    .m_all_ones(h_all_ones), .busy(h_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sends seq[7] first down to seq[0]; gap idle cycles between bits with busy checked.
  task automatic applyStimulus(input logic [7:0] seq, input int gap);
    for (int i = 7; i >= 0; i--) begin
      s_valid = 1'b1;
      s_data  = seq[i];
      tick();
      s_valid = 1'b0;
      if (i != 0) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          checkOutput("gap_busy", {31'd0, h_busy}, 32'd1);
        end
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b1;
    s_valid = 1'b0;
    s_data  = 1'b0;
    clear   = 1'b0;
    m_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_m_valid", {31'd0, l_m_valid}, 32'd0);
    checkOutput("rst_m_data", {24'd0, l_data}, 32'h00);
    checkOutput("rst_all_ones", {31'd0, l_all_ones}, 32'd0);
    checkOutput("rst_s_ready", {31'd0, l_s_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, l_busy}, 32'd0);
    #1 rst_n = 1'b1;

    $display("[TB] word 1,0,1,1,0,0,0,1 lsb-first");
    applyStimulus(8'b10110001, 0);
    checkOutput("w1_valid", {31'd0, l_m_valid}, 32'd1);
    checkOutput("w1_data", {24'd0, l_data}, 32'h8D);
    checkOutput("w1_all_ones", {31'd0, l_all_ones}, 32'd0);
    checkOutput("w1_msb_data", {24'd0, h_data}, 32'hB1);
    checkOutput("w1_s_ready", {31'd0, l_s_ready}, 32'd0);
    tick();
    checkOutput("w1_release", {31'd0, l_m_valid}, 32'd0);

    $display("[TB] all ones then single zero at bit 5");
    applyStimulus(8'hFF, 0);
    checkOutput("ff_data", {24'd0, l_data}, 32'hFF);
    checkOutput("ff_all_ones", {31'd0, l_all_ones}, 32'd1);
    tick();
    applyStimulus(8'b11111011, 0);
    checkOutput("df_data", {24'd0, l_data}, 32'hDF);
    checkOutput("df_all_ones", {31'd0, l_all_ones}, 32'd0);
    tick();

    $display("[TB] backpressure while held");
    m_ready = 1'b0;
    applyStimulus(8'hFF, 0);
    checkOutput("bp_valid", {31'd0, l_m_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1;
      s_data  = 1'b0;
      tick();
      checkOutput("bp_s_ready", {31'd0, l_s_ready}, 32'd0);
      checkOutput("bp_data", {24'd0, l_data}, 32'hFF);
      checkOutput("bp_all_ones", {31'd0, l_all_ones}, 32'd1);
    end
    m_ready = 1'b1;
    tick();
    s_valid = 1'b0;
    checkOutput("bp_release", {31'd0, l_m_valid}, 32'd0);
    checkOutput("bp_busy", {31'd0, l_busy}, 32'd0);
    applyStimulus(8'hFF, 0);
    checkOutput("bp_next_data", {24'd0, l_data}, 32'hFF);
    checkOutput("bp_next_all_ones", {31'd0, l_all_ones}, 32'd1);
    tick();

    $display("[TB] clear mid-word");
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data  = 1'b0;
      tick();
    end
    checkOutput("clr_busy_before", {31'd0, l_busy}, 32'd1);
    clear = 1'b1;
    tick();
    clear   = 1'b0;
    s_valid = 1'b0;
    checkOutput("clr_busy_after", {31'd0, l_busy}, 32'd0);
    applyStimulus(8'hFF, 0);
    checkOutput("clr_data", {24'd0, l_data}, 32'hFF);
    checkOutput("clr_all_ones", {31'd0, l_all_ones}, 32'd1);
    tick();

    $display("[TB] async reset mid-word");
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1;
      s_data  = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rmw_busy", {31'd0, l_busy}, 32'd0);
    checkOutput("rmw_s_ready", {31'd0, l_s_ready}, 32'd1);
    checkOutput("rmw_m_valid", {31'd0, l_m_valid}, 32'd0);
    rst_n = 1'b1;
    applyStimulus(8'b10110001, 0);
    checkOutput("rmw_next_data", {24'd0, l_data}, 32'h8D);
    checkOutput("rmw_next_valid", {31'd0, l_m_valid}, 32'd1);
    tick();

    $display("[TB] async reset during hold");
    m_ready = 1'b0;
    applyStimulus(8'hFF, 0);
    checkOutput("rh_valid_before", {31'd0, l_m_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rh_m_valid", {31'd0, l_m_valid}, 32'd0);
    checkOutput("rh_m_data", {24'd0, l_data}, 32'h00);
    checkOutput("rh_all_ones", {31'd0, l_all_ones}, 32'd0);
    checkOutput("rh_s_ready", {31'd0, l_s_ready}, 32'd1);
    checkOutput("rh_busy", {31'd0, l_busy}, 32'd0);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    applyStimulus(8'b11111011, 0);
    checkOutput("rh_next_data", {24'd0, l_data}, 32'hDF);
    tick();

    $display("[TB] msb-first with stalls");
    applyStimulus(8'b10110001, 2);
    checkOutput("gap_msb_valid", {31'd0, h_m_valid}, 32'd1);
    checkOutput("gap_msb_data", {24'd0, h_data}, 32'hB1);
    checkOutput("gap_msb_all_ones", {31'd0, h_all_ones}, 32'd0);
    checkOutput("gap_lsb_data", {24'd0, l_data}, 32'h8D);
    tick();
    checkOutput("gap_release", {31'd0, h_m_valid}, 32'd0);
    checkOutput("gap_busy_end", {31'd0, h_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
